// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the prefetch fetch unit (state encoding, NOP, word width, PC step)
package fetch_pkg;
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [31:0] NOP       = 32'h00000033;
  localparam int INSN_W             = 32;
  localparam int PC_INC             = 4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush, count and zero-when-empty combinational head
// Ports: clk, reset (async active-low), flush, push/push_data, pop, count, head.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= push_data;
  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit: instruction fetch front end with one outstanding bus request and a prefetch queue
// Ports: clk, reset (async active-low); instruction_* bus request/response; fetch_* valid/ready
// head to decode; redirect_valid/redirect_address restart fetch.
// Optional macro FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and halts on unaligned redirects.
module prefetch_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = INSN_W,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int              QUEUE_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instruction_request,
  output logic [XLEN-1:0] instruction_address,
  input  logic            instruction_response,
  input  logic [XLEN-1:0] instruction_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_instruction,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_address
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic [1:0] state;
  logic [XLEN-1:0] next_pc, req_pc, inc_pc;
  logic [CW-1:0] count;
  logic pop, push, room_fetch, room_wait, bad_redirect, blocked;
  assign inc_pc = req_pc + XLEN'(PC_INC);
  assign pop = fetch_valid && fetch_ready;
  assign push = state == ST_WAIT && instruction_response && !redirect_valid;
  assign room_fetch = (count - CW'(pop)) < CW'(QUEUE_DEPTH);
  assign room_wait = (count + CW'(1) - CW'(pop)) < CW'(QUEUE_DEPTH);
  assign fetch_valid = count != '0;
  assign instruction_request = state != ST_FETCH;
  assign instruction_address = req_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_redirect = redirect_valid && (redirect_address[1:0] != 2'b00);
  assign blocked = fetch_misaligned;
  always_ff @(posedge clk or negedge reset)
    if (!reset) fetch_misaligned <= 1'b0;
    else if (redirect_valid) fetch_misaligned <= bad_redirect;
`else
  assign bad_redirect = 1'b0;
  assign blocked = 1'b0;
`endif
  // A redirect that coincides with a response has no bus transaction left to drain, so it
  // starts the new request directly; otherwise the outstanding request is drained in DISCARD.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= ST_FETCH;
      next_pc <= BOOT_ADDRESS;
      req_pc  <= '0;
    end else if (redirect_valid) begin
      next_pc <= redirect_address;
      if (bad_redirect)
        state <= (state != ST_FETCH && !instruction_response) ? ST_DISCARD : ST_FETCH;
      else if (state == ST_FETCH || instruction_response) begin
        state  <= ST_WAIT;
        req_pc <= redirect_address;
      end else
        state <= ST_DISCARD;
    end else if (state == ST_FETCH && room_fetch && !blocked) begin
      state  <= ST_WAIT;
      req_pc <= next_pc;
    end else if (state == ST_WAIT && instruction_response) begin
      next_pc <= inc_pc;
      if (room_wait) req_pc <= inc_pc;
      else state <= ST_FETCH;
    end else if (state == ST_DISCARD && instruction_response) begin
      state  <= blocked ? ST_FETCH : ST_WAIT;
      req_pc <= next_pc;
    end
  fetch_queue #(.W(2 * XLEN), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc, instruction_data}),
    .pop       (pop && !redirect_valid),
    .count     (count),
    .head      ({fetch_pc, fetch_instruction})
  );
endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb_prefetch_fetch_unit: directed self-checking bench for prefetch_fetch_unit
module tb_prefetch_fetch_unit;
  logic clk = 0, reset = 0;
  logic instruction_request, instruction_response, fetch_valid;
  logic fetch_ready = 0, redirect_valid = 0;
  logic [31:0] instruction_address, instruction_data, fetch_instruction, fetch_pc;
  logic [31:0] redirect_address = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misaligned;
`endif
  int checks = 0, errors = 0, lat = 0, wcnt = 0;
  logic found, saw8;

  always #5 clk = ~clk;
  always @(posedge clk) wcnt <= (instruction_request && !instruction_response) ? wcnt + 1 : 0;
  assign instruction_response = instruction_request && wcnt >= lat;
  assign instruction_data = instruction_response ? instruction_address + 32'h1000_0000 : 32'h0;

  prefetch_fetch_unit #(.XLEN(32), .BOOT_ADDRESS(32'h0), .QUEUE_DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction_request  (instruction_request),
    .instruction_address  (instruction_address),
    .instruction_response (instruction_response),
    .instruction_data     (instruction_data),
    .fetch_valid          (fetch_valid),
    .fetch_ready          (fetch_ready),
    .fetch_instruction    (fetch_instruction),
    .fetch_pc             (fetch_pc),
    .redirect_valid       (redirect_valid),
    .redirect_address     (redirect_address)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned     (fetch_misaligned)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0;
    repeat (2) tick;
    reset = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset values
    reset = 0;
    #12;
    chk("rst_req", instruction_request, 0);
    chk("rst_addr", instruction_address, 0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_insn", fetch_instruction, 0);
    chk("rst_pc", fetch_pc, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_mis", fetch_misaligned, 0);
`endif
    // zero-wait streaming
    lat = 0; fetch_ready = 1;
    do_reset;
    chk("t1_c0_req", instruction_request, 0);
    tick;
    chk("t1_req0", instruction_request, 1);
    chk("t1_addr0", instruction_address, 32'h0);
    chk("t1_valid0", fetch_valid, 0);
    tick;
    chk("t1_addr4", instruction_address, 32'h4);
    chk("t1_pc0", fetch_pc, 32'h0);
    chk("t1_insn0", fetch_instruction, word(32'h0));
    tick;
    chk("t1_addr8", instruction_address, 32'h8);
    chk("t1_pc4", fetch_pc, 32'h4);
    chk("t1_insn4", fetch_instruction, word(32'h4));
    tick;
    chk("t1_pc8", fetch_pc, 32'h8);
    chk("t1_insn8", fetch_instruction, word(32'h8));
    // queue fills with decode stalled
    fetch_ready = 0;
    do_reset;
    repeat (4) tick;
    chk("t2_addrC", instruction_address, 32'hC);
    chk("t2_reqC", instruction_request, 1);
    tick;
    chk("t2_full_req", instruction_request, 0);
    chk("t2_head_pc", fetch_pc, 32'h0);
    tick;
    chk("t2_stall_req", instruction_request, 0);
    fetch_ready = 1;
    tick;
    fetch_ready = 0;
    chk("t2_req10", instruction_request, 1);
    chk("t2_addr10", instruction_address, 32'h10);
    chk("t2_pc_after_pop", fetch_pc, 32'h4);
    tick;
    chk("t2_refull_req", instruction_request, 0);
    // redirect during a slow outstanding request
    lat = 3; fetch_ready = 1;
    do_reset;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      found = instruction_request && instruction_address == 32'h8;
    end
    chk("t3_req8_seen", found, 1);
    tick;
    redirect_valid = 1; redirect_address = 32'h100;
    tick;
    redirect_valid = 0;
    chk("t3_hold_req", instruction_request, 1);
    chk("t3_hold_addr", instruction_address, 32'h8);
    saw8 = 0;
    for (int i = 0; i < 20 && !(instruction_request && instruction_address != 32'h8); i++) begin
      tick;
      if (fetch_valid && fetch_pc == 32'h8) saw8 = 1;
    end
    chk("t3_new_addr", instruction_address, 32'h100);
    for (int i = 0; i < 20 && !fetch_valid; i++) begin
      tick;
      if (fetch_valid && fetch_pc == 32'h8) saw8 = 1;
    end
    chk("t3_valid", fetch_valid, 1);
    chk("t3_first_pc", fetch_pc, 32'h100);
    chk("t3_first_insn", fetch_instruction, word(32'h100));
    chk("t3_no_stale8", saw8, 0);
    // redirect colliding with response and pop
    lat = 0; fetch_ready = 1;
    do_reset;
    repeat (3) tick;
    chk("t4_pre_valid", fetch_valid, 1);
    redirect_valid = 1; redirect_address = 32'h200;
    tick;
    redirect_valid = 0;
    chk("t4_empty", fetch_valid, 0);
    chk("t4_req", instruction_request, 1);
    chk("t4_addr", instruction_address, 32'h200);
    tick;
    chk("t4_pc", fetch_pc, 32'h200);
    // PC wrap
    do_reset;
    tick;
    redirect_valid = 1; redirect_address = 32'hFFFF_FFF8;
    tick;
    redirect_valid = 0;
    chk("wrap_addr_f8", instruction_address, 32'hFFFF_FFF8);
    repeat (2) tick;
    chk("wrap_addr_0", instruction_address, 32'h0);
    chk("wrap_pc_fc", fetch_pc, 32'hFFFF_FFFC);
    // asynchronous reset mid-WAIT
    lat = 3; fetch_ready = 0;
    do_reset;
    repeat (5) tick;
    chk("t5_pre_valid", fetch_valid, 1);
    reset = 0;
    #1;
    chk("t5_req", instruction_request, 0);
    chk("t5_addr", instruction_address, 0);
    chk("t5_valid", fetch_valid, 0);
    chk("t5_pc", fetch_pc, 0);
    chk("t5_insn", fetch_instruction, 0);
    tick;
    reset = 1;
    tick;
    chk("t5_boot_req", instruction_request, 1);
    chk("t5_boot_addr", instruction_address, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    lat = 0; fetch_ready = 1;
    do_reset;
    tick;
    redirect_valid = 1; redirect_address = 32'h102;
    tick;
    redirect_valid = 0;
    chk("mis_flag", fetch_misaligned, 1);
    chk("mis_req", instruction_request, 0);
    chk("mis_valid", fetch_valid, 0);
    repeat (2) tick;
    chk("mis_hold_req", instruction_request, 0);
    redirect_valid = 1; redirect_address = 32'h104;
    tick;
    redirect_valid = 0;
    chk("mis_clear", fetch_misaligned, 0);
    chk("mis_req104", instruction_request, 1);
    chk("mis_addr104", instruction_address, 32'h104);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
